net_bus_rx7: RTL and testbench

- Receive-side counterpart of the NetBus 7-way transmit fan-out.
- Merges seven independent NetBus input streams into one output stream using packet-locked round-robin arbitration.
- Each granted packet passes through whole, never interleaved, via a single registered output stage; the source port travels with each word.
- Sits between seven upstream NetBus links and a single downstream consumer.

---
 rtl/net_bus_rx7_if.sv | 25 ++
 rtl/net_bus_rx7.sv | 104 ++++++++++
 tb/tb_net_bus_rx7.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/net_bus_rx7_if.sv
// Seven NetBus receive links plus the merged output link of net_bus_rx7.
// The slave modport is the merger; the master modport is its environment.
interface net_bus_rx7_if #(
  parameter int DATA_WIDTH = 4
);
  localparam int W = DATA_WIDTH*9+14;

  logic [6:0][W-1:0] rdata;
  logic [6:0]        rvalid;
  logic [6:0]        rready;
  logic [W-1:0]      data;
  logic              valid;
  logic              ready;
  logic [2:0]        owner;

  modport slave (
    input  rdata, rvalid, ready,
    output rready, data, valid, owner
  );

  modport master (
    output rdata, rvalid, ready,
    input  rready, data, valid, owner
  );
endinterface

// File: rtl/net_bus_rx7.sv
// Seven-to-one NetBus merger: packet-locked round-robin arbitration feeding a
// single registered output stage that carries the source port with each word.
module net_bus_rx7 #(
  parameter int DATA_WIDTH = 4,
  parameter int LAST_BIT   = DATA_WIDTH*9+13
) (
  input logic          clk,
  input logic          rst,
  net_bus_rx7_if.slave bus
);
  localparam int W = DATA_WIDTH*9+14;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t       state, state_next;
  logic [2:0]   g, g_next;
  logic [2:0]   ptr, ptr_next;
  logic [W-1:0] data_q;
  logic         valid_q;
  logic [2:0]   owner_q;
  logic [6:0]   rready;
  logic         accept;
  logic [W-1:0] word;
  logic         last;

  // First requesting port at or after start, wrapping 6 -> 0.
  function automatic logic [2:0] rr_pick(input logic [6:0] req, input logic [2:0] start);
    logic [2:0] pick;
    logic [3:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      idx = {1'b0, start} + 4'(i);
      if (idx >= 4'd7) idx = idx - 4'd7;
      if (!found && req[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign word = bus.rdata[g];
  assign last = word[LAST_BIT];

  always_comb begin
    state_next = state;
    g_next     = g;
    ptr_next   = ptr;
    rready     = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.rvalid) begin
          g_next     = rr_pick(bus.rvalid, ptr);
          state_next = LOCK;
        end
      end
      LOCK: begin
        // The granted port may push whenever the output stage can take a word.
        rready[g] = ~valid_q | bus.ready;
        accept    = bus.rvalid[g] & rready[g];
        if (accept && last) begin
          state_next = IDLE;
          ptr_next   = (g == 3'd6) ? 3'd0 : g + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      g     <= g_next;
      ptr   <= ptr_next;
    end
  end

  // A stalled word holds; an accept refills even while the old word drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
    end else if (accept) begin
      data_q  <= word;
      valid_q <= 1'b1;
      owner_q <= g;
    end else if (bus.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.rready = rready;
  assign bus.data   = data_q;
  assign bus.valid  = valid_q;
  assign bus.owner  = owner_q;
endmodule

// File: tb/tb_net_bus_rx7.sv
// Self-checking bench for net_bus_rx7: a vector table for a single packet,
// directed multi-cycle sequences, and randomized traffic against a packet model.
module tb_net_bus_rx7;
  localparam int DATA_WIDTH = 4;
  localparam int W  = DATA_WIDTH*9+14;
  localparam int LB = W-1;
  localparam int SW = W-20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  net_bus_rx7_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  net_bus_rx7 #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [2:0]   port;
    logic [W-1:0] word;
  } xfer_t;

  typedef struct {
    logic [6:0]   rv;
    logic [W-1:0] wd;
    logic         rdy;
    logic [6:0]   exp_rready;
    logic         exp_valid;
    logic [2:0]   exp_owner;
    logic [W-1:0] exp_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] pending [7][$];
  int           gap [7];
  int           seq_cnt [7];
  xfer_t        expq [$];
  int           out_own [$];
  int           out_cyc [$];
  int           cyc;
  logic         rdy;
  int           stall_left;
  logic [W-1:0] stall_word;

  logic         model_idle;
  int           model_ptr;
  int           model_g;
  logic         prev_hold;
  logic [W-1:0] prev_data;
  logic [2:0]   prev_owner;

  function automatic logic [W-1:0] mk_word(input int p, input int s, input bit last, input int unsigned salt);
    logic [W-1:0] w;
    w          = '0;
    w[LB]      = last;
    w[2:0]     = 3'(p);
    w[18:3]    = 16'(s);
    w[LB-1:19] = SW'(salt);
    return w;
  endfunction

  function automatic int rr_first(input logic [6:0] v, input int from);
    for (int i = 0; i < 7; i++)
      if (v[(from + i) % 7]) return (from + i) % 7;
    return -1;
  endfunction

  function automatic int pending_total();
    int n = 0;
    for (int p = 0; p < 7; p++) n += pending[p].size();
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic clear_model();
    for (int p = 0; p < 7; p++) begin
      pending[p].delete();
      gap[p] = 0;
    end
    bus.rvalid = '0;
    expq.delete();
    out_own.delete();
    out_cyc.delete();
    model_idle = 1'b1;
    model_ptr  = 0;
    model_g    = 0;
    prev_hold  = 1'b0;
    stall_left = 0;
    cyc        = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Observes one cycle: output transfers against the accept order, output hold
  // under back-pressure, and grant legality against the round-robin rules.
  task automatic monitor();
    logic [6:0] acc;
    logic [6:0] er;
    xfer_t      x;
    acc = bus.rvalid & bus.rready;
    if (prev_hold) begin
      checkOutput("hold_valid", 64'(bus.valid), 64'd1);
      checkOutput("hold_data", 64'(bus.data), 64'(prev_data));
      checkOutput("hold_owner", 64'(bus.owner), 64'(prev_owner));
    end
    if (bus.valid && bus.ready) begin
      if (expq.size() == 0) begin
        fail_now("out_without_accept");
      end else begin
        x = expq.pop_front();
        checkOutput("out_owner", 64'(bus.owner), 64'(x.port));
        checkOutput("out_data", 64'(bus.data), 64'(x.word));
      end
      out_own.push_back(int'(bus.owner));
      out_cyc.push_back(cyc);
    end
    prev_hold  = bus.valid && !bus.ready;
    prev_data  = bus.data;
    prev_owner = bus.owner;
    if (model_idle) begin
      checkOutput("idle_rready", 64'(bus.rready), 64'd0);
      if (bus.rvalid != '0) begin
        model_g    = rr_first(bus.rvalid, model_ptr);
        model_idle = 1'b0;
      end
    end else begin
      er          = '0;
      er[model_g] = !bus.valid || bus.ready;
      checkOutput("lock_rready", 64'(bus.rready), 64'(er));
    end
    for (int p = 0; p < 7; p++) begin
      if (acc[p]) begin
        expq.push_back('{3'(p), bus.rdata[p]});
        if (pending[p].size() != 0) void'(pending[p].pop_front());
      end
    end
    if (!model_idle && acc[model_g] && bus.rdata[model_g][LB]) begin
      model_idle = 1'b1;
      model_ptr  = (model_g + 1) % 7;
    end
    cyc++;
  endtask

  task automatic applyStimulus();
    logic [6:0] rv;
    @(negedge clk);
    for (int p = 0; p < 7; p++) begin
      rv[p]        = (pending[p].size() != 0) && (gap[p] == 0);
      bus.rdata[p] = (pending[p].size() != 0) ? pending[p][0] : '0;
      if (gap[p] > 0) gap[p]--;
    end
    bus.rvalid = rv;
    if (stall_left > 0 && bus.valid && bus.data == stall_word) begin
      bus.ready = 1'b0;
      stall_left--;
    end else begin
      bus.ready = rdy;
    end
    #1;
    monitor();
  endtask

  initial begin
    vec_t         tbl [7];
    logic [W-1:0] w [5];
    int           len;
    logic         started;

    rst        = 1'b0;
    rdy        = 1'b1;
    stall_word = '0;
    bus.rdata  = '0;
    bus.ready  = 1'b1;
    for (int p = 0; p < 7; p++) seq_cnt[p] = 0;
    clear_model();

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_valid", 64'(bus.valid), 64'd0);
    checkOutput("reset_data", 64'(bus.data), 64'd0);
    checkOutput("reset_owner", 64'(bus.owner), 64'd0);
    checkOutput("reset_rready", 64'(bus.rready), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Port 3 sends a 4-word packet with READY held high.
    for (int k = 0; k < 4; k++) w[k] = mk_word(3, k, k == 3, 32'hA5A50000 + k);
    tbl[0] = '{7'h08, w[0], 1'b1, 7'h00, 1'b0, 3'd0, '0};
    tbl[1] = '{7'h08, w[0], 1'b1, 7'h08, 1'b0, 3'd0, '0};
    tbl[2] = '{7'h08, w[1], 1'b1, 7'h08, 1'b1, 3'd3, w[0]};
    tbl[3] = '{7'h08, w[2], 1'b1, 7'h08, 1'b1, 3'd3, w[1]};
    tbl[4] = '{7'h08, w[3], 1'b1, 7'h08, 1'b1, 3'd3, w[2]};
    tbl[5] = '{7'h00, w[3], 1'b1, 7'h00, 1'b1, 3'd3, w[3]};
    tbl[6] = '{7'h00, w[3], 1'b1, 7'h00, 1'b0, 3'd3, '0};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.rvalid   = tbl[i].rv;
      bus.rdata[3] = tbl[i].wd;
      bus.ready    = tbl[i].rdy;
      #1;
      checkOutput("t1_rready", 64'(bus.rready), 64'(tbl[i].exp_rready));
      checkOutput("t1_valid", 64'(bus.valid), 64'(tbl[i].exp_valid));
      checkOutput("t1_owner", 64'(bus.owner), 64'(tbl[i].exp_owner));
      if (tbl[i].exp_valid) checkOutput("t1_data", 64'(bus.data), 64'(tbl[i].exp_data));
    end

    // All ports offer single-word packets: strict rotation with a bubble each.
    do_reset();
    rdy = 1'b1;
    for (int p = 0; p < 7; p++)
      for (int k = 0; k < 2; k++) pending[p].push_back(mk_word(p, k, 1'b1, $urandom));
    for (int i = 0; i < 60 && out_own.size() < 9; i++) applyStimulus();
    checkOutput("t2_count", 64'(out_own.size()), 64'd9);
    for (int i = 0; i < 9 && i < out_own.size(); i++) begin
      checkOutput("t2_owner", 64'(out_own[i]), 64'(i % 7));
      if (i > 0) checkOutput("t2_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
    end

    // Port 2, 5 words, READY low for 3 cycles while word 2 sits on DATA.
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w[k] = mk_word(2, k, k == 4, $urandom);
      pending[2].push_back(w[k]);
    end
    stall_word = w[1];
    stall_left = 3;
    for (int i = 0; i < 60 && out_own.size() < 5; i++) begin
      applyStimulus();
      if (!bus.ready) begin
        checkOutput("t3_stall_rready2", 64'(bus.rready[2]), 64'd0);
        checkOutput("t3_stall_data", 64'(bus.data), 64'(w[1]));
      end
    end
    checkOutput("t3_count", 64'(out_own.size()), 64'd5);
    checkOutput("t3_stall_used", 64'(stall_left), 64'd0);

    // Port 1 requests mid-packet while port 2 pauses; port 1 waits for LAST.
    do_reset();
    rdy     = 1'b1;
    started = 1'b0;
    for (int k = 0; k < 4; k++) pending[2].push_back(mk_word(2, k, k == 3, $urandom));
    for (int i = 0; i < 80 && out_own.size() < 5; i++) begin
      if (!started && pending[2].size() == 3) begin
        started = 1'b1;
        gap[2]  = 2;
        pending[1].push_back(mk_word(1, 0, 1'b1, $urandom));
      end
      applyStimulus();
      if (pending[2].size() != 0) checkOutput("t4_rready1_blocked", 64'(bus.rready[1]), 64'd0);
    end
    checkOutput("t4_count", 64'(out_own.size()), 64'd5);
    if (out_own.size() == 5) checkOutput("t4_next_owner", 64'(out_own[4]), 64'd1);

    // Asynchronous reset in the middle of a port 4 packet.
    do_reset();
    rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w[k] = mk_word(4, k, k == 2, $urandom);
      pending[4].push_back(w[k]);
    end
    for (int i = 0; i < 40; i++) begin
      applyStimulus();
      if (bus.valid && bus.data == w[1]) break;
    end
    checkOutput("t5_word2_on_data", 64'(bus.data), 64'(w[1]));
    checkOutput("t5_pre_rready4", 64'(bus.rready), 64'h10);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_async_valid", 64'(bus.valid), 64'd0);
    checkOutput("t5_async_rready", 64'(bus.rready), 64'd0);
    checkOutput("t5_async_owner", 64'(bus.owner), 64'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    pending[0].push_back(mk_word(0, 0, 1'b1, $urandom));
    pending[5].push_back(mk_word(5, 0, 1'b1, $urandom));
    for (int i = 0; i < 20 && out_own.size() < 2; i++) applyStimulus();
    checkOutput("t5_count", 64'(out_own.size()), 64'd2);
    if (out_own.size() == 2) begin
      checkOutput("t5_first_owner", 64'(out_own[0]), 64'd0);
      checkOutput("t5_second_owner", 64'(out_own[1]), 64'd5);
    end

    // Port 6 alone sends two 2-word packets back to back, then races port 0.
    out_own.delete();
    out_cyc.delete();
    for (int k = 0; k < 4; k++) pending[6].push_back(mk_word(6, k, k == 1 || k == 3, $urandom));
    for (int i = 0; i < 40 && out_own.size() < 4; i++) applyStimulus();
    checkOutput("t6_count", 64'(out_own.size()), 64'd4);
    if (out_own.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("t6_owner", 64'(out_own[i]), 64'd6);
      checkOutput("t6_in_packet_gap", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
      checkOutput("t6_bubble_gap", 64'(out_cyc[2] - out_cyc[1]), 64'd2);
    end
    out_own.delete();
    out_cyc.delete();
    pending[6].push_back(mk_word(6, 4, 1'b1, $urandom));
    pending[0].push_back(mk_word(0, 1, 1'b1, $urandom));
    for (int i = 0; i < 20 && out_own.size() < 2; i++) applyStimulus();
    checkOutput("t6_race_count", 64'(out_own.size()), 64'd2);
    if (out_own.size() == 2) begin
      checkOutput("t6_race_first", 64'(out_own[0]), 64'd0);
      checkOutput("t6_race_second", 64'(out_own[1]), 64'd6);
    end

    // Random traffic: packet lengths, RVALID gaps and READY stalls all vary.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 7; p++) begin
        if (pending[p].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++) begin
            pending[p].push_back(mk_word(p, seq_cnt[p], k == len - 1, $urandom));
            seq_cnt[p]++;
          end
        end
        if (gap[p] == 0 && $urandom_range(0, 7) == 0) gap[p] = $urandom_range(1, 3);
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    rdy = 1'b1;
    for (int i = 0; i < 400 && (pending_total() != 0 || expq.size() != 0); i++) applyStimulus();
    checkOutput("rand_drain_inputs", 64'(pending_total()), 64'd0);
    checkOutput("rand_drain_output", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
